// File: rtl/fixedpoint_div_scheduler.sv
// Issues one Q9.7 divide at a time to an external divider and returns the result with its tag.
// Optional macro DIV_SATURATE_EN clamps the quotient to full scale when the divider reports overflow.
module fixedpoint_div_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_dividend,
  input  logic [15:0] in_divisor,
  input  logic [3:0]  in_tag,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  output logic        div_enable,
  input  logic [15:0] div_quotient,
  input  logic        div_overflow,
  input  logic        div_divbyzero,
  input  logic        div_error,
  input  logic        div_finished,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_quotient,
  output logic [3:0]  out_tag,
  output logic [3:0]  out_status,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait_cnt;
  logic          r_fin_d;
  logic [15:0]   r_dividend;
  logic [15:0]   r_divisor;
  logic [15:0]   r_quot;
  logic [3:0]    r_tag;
  logic [3:0]    r_status;
  logic [7:0]    r_err_cnt;
  logic          w_fin_edge;
  logic          w_timeout;
  logic          w_accept;
  logic          w_transfer;
  logic [15:0]   w_res_quot;

  assign w_fin_edge = div_finished & ~r_fin_d;
  assign w_timeout  = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_accept   = (r_state == S_IDLE) & in_valid;
  assign w_transfer = (r_state == S_HOLD) & out_ready;

`ifdef DIV_SATURATE_EN
  // Clamp direction follows the sign of the true quotient, taken from the captured operands.
  always_comb begin
    w_res_quot = div_quotient;
    if (div_overflow)
      w_res_quot = (r_dividend[15] == r_divisor[15]) ? 16'h7FFF : 16'h8000;
  end
`else
  assign w_res_quot = div_quotient;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = (in_divisor == '0) ? S_HOLD : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_fin_edge || w_timeout) w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_fin_d    <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_tag      <= '0;
      r_status   <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_fin_d    <= div_finished;
      r_wait_cnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_dividend <= in_dividend;
        r_divisor  <= in_divisor;
        r_tag      <= in_tag;
        if (in_divisor == '0) begin
          r_quot   <= '0;
          r_status <= 4'b0110;
        end
      end
      // A completion edge wins over a timeout landing on the same cycle.
      if (r_state == S_WAIT) begin
        if (w_fin_edge) begin
          r_quot   <= w_res_quot;
          r_status <= {1'b0, div_error | div_overflow | div_divbyzero, div_divbyzero, div_overflow};
        end else if (w_timeout) begin
          r_quot   <= '0;
          r_status <= 4'b1100;
        end
      end
      if (w_transfer && r_status[2] && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign div_enable   = (r_state == S_ISSUE);
  assign out_valid    = (r_state == S_HOLD);
  assign busy         = (r_state != S_IDLE);
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign out_quotient = r_quot;
  assign out_tag      = r_tag;
  assign out_status   = r_status;
  assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_fixedpoint_div_scheduler.sv
// Directed and randomized checks of fixedpoint_div_scheduler against a behavioural result model
// with a cycle-counting divider stub; honours DIV_SATURATE_EN for the expected quotient.
module tb_fixedpoint_div_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dividend;
  logic [15:0] in_divisor;
  logic [3:0]  in_tag;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_enable;
  logic [15:0] div_quotient;
  logic        div_overflow;
  logic        div_divbyzero;
  logic        div_error;
  logic        div_finished;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quotient;
  logic [3:0]  out_tag;
  logic [3:0]  out_status;
  logic [7:0]  err_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  fixedpoint_div_scheduler #(.TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_enable(div_enable),
    .div_quotient(div_quotient), .div_overflow(div_overflow), .div_divbyzero(div_divbyzero),
    .div_error(div_error), .div_finished(div_finished), .out_valid(out_valid),
    .out_ready(out_ready), .out_quotient(out_quotient), .out_tag(out_tag),
    .out_status(out_status), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction; the stub raises div_finished for one cycle, lat cycles after enable.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input int lat, input logic [15:0] q, input logic ovf, input logic err,
                        input logic dbz, input int rdy_delay, input bit hold_valid);
    bit          divz;
    bit          tmo;
    bit          seen;
    logic [15:0] eq;
    logic [3:0]  es;
    int          exp_k;
    int          k;
    int          n_en;
    divz = (b == 16'h0000);
    tmo  = !divz && (lat > 32);
    if (divz) begin
      eq = 16'h0000; es = 4'b0110; exp_k = 0;
    end else if (tmo) begin
      eq = 16'h0000; es = 4'b1100; exp_k = 33;
    end else begin
      eq = q;
      es = {1'b0, ovf | err | dbz, dbz, ovf};
      exp_k = lat + 1;
`ifdef DIV_SATURATE_EN
      if (ovf) eq = (a[15] == b[15]) ? 16'h7FFF : 16'h8000;
`endif
    end

    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_tag = tag;
    step();
    if (!hold_valid) in_valid = 1'b0;
    chk("div_dividend", div_dividend, a);
    chk("div_divisor", div_divisor, b);

    k = 0; n_en = 0; seen = 0;
    while (k <= 40) begin
      if (div_enable) n_en++;
      if (out_valid) begin
        seen = 1;
        break;
      end
      div_finished  = !divz && (k == lat);
      div_quotient  = (k == lat) ? q : ~q;
      div_overflow  = (k == lat) ? ovf : ~ovf;
      div_error     = (k == lat) ? err : ~err;
      div_divbyzero = (k == lat) ? dbz : ~dbz;
      step();
      k++;
    end
    div_finished = 1'b0;
    chk("valid_seen", seen, 1);
    chk("valid_latency", k, exp_k);
    chk("enable_pulses", n_en, divz ? 0 : 1);

    for (int i = 0; i <= rdy_delay; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_quotient", out_quotient, eq);
      chk("hold_tag", out_tag, tag);
      chk("hold_status", out_status, es);
      chk("hold_in_ready", in_ready, 0);
      if (i < rdy_delay) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (es[2] && exp_err < 255) exp_err++;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("err_count", err_count, exp_err);
    step();
    chk("single_transfer_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; in_tag = '0;
    div_quotient = '0; div_overflow = 0; div_divbyzero = 0; div_error = 0; div_finished = 0;
    out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_enable", div_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", out_quotient, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_status", out_status, 0);
    chk("rst_err", err_count, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_in_ready", in_ready, 1);

    // 7.0 / -2.0
    run_op(16'h0380, 16'hFF00, 4'h5, 12, 16'hFE40, 0, 0, 0, 0, 0);
    // 7.0 / 0
    run_op(16'h0380, 16'h0000, 4'hA, 0, 16'h0000, 0, 0, 0, 1, 0);
    // overflow cases, equal and differing signs
    run_op(16'h4000, 16'h0040, 4'h3, 5, 16'h1234, 1, 0, 0, 0, 0);
    run_op(16'h9C00, 16'h0040, 4'h4, 7, 16'h1234, 1, 0, 0, 0, 0);
    // divider never finishes
    run_op(16'h0100, 16'h0080, 4'h6, 1000, 16'h5555, 0, 0, 0, 0, 0);
    // backpressure with in_valid held high
    run_op(16'h0200, 16'h0100, 4'h9, 3, 16'h0100, 0, 1, 0, 5, 1);
    // completion on the last allowed WAIT cycle, then one cycle too late
    run_op(16'h0300, 16'h0100, 4'hC, 32, 16'h0300, 0, 0, 0, 0, 0);
    run_op(16'h0300, 16'h0100, 4'hD, 33, 16'h0300, 0, 0, 0, 0, 0);
    // minimum latency and flag combinations
    run_op(16'hF000, 16'h0F00, 4'h1, 1, 16'hFEEE, 0, 0, 1, 2, 0);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(ra, rb, 4'($urandom), int'($urandom_range(1, 40)), 16'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)));
    end

    // drive the error counter into saturation with divide-by-zero requests
    for (int n = 0; n < 260; n++) begin
      in_valid = 1'b1; in_divisor = 16'h0000; in_dividend = 16'($urandom); in_tag = 4'($urandom);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (exp_err < 255) exp_err++;
    end
    chk("err_saturated", err_count, exp_err);
    chk("err_saturated_ff", err_count, 8'hFF);

    // reset mid-WAIT, then a stale finished edge
    in_valid = 1'b1; in_dividend = 16'h0380; in_divisor = 16'h0100; in_tag = 4'h7;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("midwait_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_err = 0;
    div_finished = 1'b1; div_overflow = 1'b1; div_quotient = 16'hBEEF;
    step();
    div_finished = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stale_out_valid", out_valid, 0);
      chk("stale_busy", busy, 0);
      step();
    end
    chk("stale_err", err_count, exp_err);
    chk("stale_div_divisor", div_divisor, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixedpoint_div_scheduler.md
FIXEDPOINT_DIV_SCHEDULER -- requirements
Module: fixedpoint_div_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: maximum cycles in WAIT before the divide is abandoned.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  block can accept an operand pair.
REQ-006 in_dividend, in_divisor  in  16 each  signed Q9.7 operands.
REQ-007 in_tag  in  4  caller identifier, returned with the result.
REQ-008 div_dividend, div_divisor  out  16 each  registered operands driven to the divider.
REQ-009 div_enable  out  1  start pulse to the divider.
REQ-010 div_quotient  in  16; div_overflow, div_divbyzero, div_error, div_finished  in  1 each  divider results.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_quotient  out  16  Q9.7 result.
REQ-014 out_tag  out  4  tag of the result.
REQ-015 out_status  out  4  {timeout, error, divbyzero, overflow}.
REQ-016 err_count  out  8  count of delivered results with error=1.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, HOLD; in_ready=1 only in IDLE.
REQ-019 IDLE, in_valid=1: capture operands and tag; divisor==0 -> HOLD, else -> ISSUE.
REQ-020 ISSUE: div_enable=1 for exactly one cycle, then WAIT; div_enable=0 in all other states.
REQ-021 div_dividend/div_divisor hold captured values from capture until the next capture.
REQ-022 WAIT: completion is a rising edge of div_finished (high now, low the previous cycle); a level held over from a prior operation is ignored.
REQ-023 On completion: latch div_quotient and flags into the output registers, go to HOLD; out_valid rises the next cycle.
REQ-024 Divide-by-zero bypass: no div_enable issued; out_quotient=0x0000, out_status=4'b0110; out_valid on the cycle after acceptance.
REQ-025 Timeout: WAIT counter reaches TIMEOUT_CYCLES with no completion -> out_quotient=0x0000, out_status=4'b1100, HOLD.
REQ-026 out_status[2] (error) = div_error OR div_overflow OR div_divbyzero on normal completion.
REQ-027 HOLD: out_valid=1; out_quotient/out_tag/out_status stable while out_ready=0.
REQ-028 HOLD with out_ready=1: transfer completes, return to IDLE.
REQ-029 No new operands are accepted during the transfer cycle (in_ready rises the cycle after).
REQ-030 err_count increments on each completed transfer with out_status[2]=1 and saturates at 0xFF.
REQ-031 A div_finished edge outside WAIT is ignored.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE.
REQ-033 Reset values: out_valid=0, div_enable=0, busy=0, out_quotient=0, out_tag=0, out_status=0, err_count=0, div_dividend=0, div_divisor=0, WAIT counter=0.
REQ-034 Reset mid-operation discards the pending operation with no out_valid; a divider completion arriving after release is ignored (REQ-031).

Configuration
REQ-035 DIV_SATURATE_EN defined: on normal completion with div_overflow=1, out_quotient=0x7FFF when the operand signs are equal, 0x8000 when they differ.
REQ-036 DIV_SATURATE_EN undefined: out_quotient=div_quotient unmodified; status flags are identical in both builds.

Verification
REQ-037 7.0/-2.0 (0x0380/0xFF00); stub asserts finished 12 cycles after enable with 0xFE40 -> one div_enable pulse; out_quotient=0xFE40; out_status=0; tag echoed.
REQ-038 7.0/0 (0x0380/0x0000) -> no div_enable; out_valid one cycle after acceptance; out_quotient=0x0000; out_status=4'b0110; err_count +1.
REQ-039 128/0.5 (0x4000/0x0040) and -200/0.5 (0x9C00/0x0040); stub overflow=1, quotient 0x1234 -> with macro 0x7FFF and 0x8000, without macro 0x1234; status 4'b0101 in both builds.
REQ-040 Stub never finishes, TIMEOUT_CYCLES=32 -> out_valid after 32 WAIT cycles; out_status=4'b1100; out_quotient=0x0000.
REQ-041 out_ready held 0 for 5 cycles in HOLD, with in_valid=1 throughout -> outputs stable; in_ready=0; exactly one transfer.
REQ-042 rst_n=0 for one cycle mid-WAIT, then a stale finished edge -> block in IDLE, no out_valid, err_count=0.
